// File: rtl/uart_fifo_transceiver.sv
// Buffered 8N1 UART: serial TX/RX engines, one FWFT FIFO per direction and the
// glue that launches TX bytes and stores received ones.

module uart_fifo_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count, count_d;
  logic             do_wr, do_rd;

  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign rdata = empty ? '0 : mem[rptr];

  always_comb begin
    count_d = count;
    if (do_wr && !do_rd)      count_d = count + CW'(1);
    else if (do_rd && !do_wr) count_d = count - CW'(1);
  end

  // Flags are registered from the next occupancy so they line up with count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wdata;
  end
endmodule

module uart_fifo_transceiver #(
  parameter int unsigned CLK_HZ       = 25000000,
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rxd,
  output logic                    txd,
  input  logic                    tx_write,
  input  logic [PAYLOAD_BITS-1:0] tx_data,
  output logic                    tx_full,
  output logic                    tx_empty,
  input  logic                    rx_read,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_empty,
  output logic                    rx_full,
  output logic                    rx_break,
  output logic                    rx_overrun
);
  localparam int unsigned CPB  = CLK_HZ / BIT_RATE;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CNTW = $clog2(CPB);
  localparam int unsigned IDXW = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  logic [PAYLOAD_BITS-1:0] tx_head, tx_byte, tx_sh, tx_sh_d;
  logic                    tx_pop, tx_launch, tx_busy, txd_d;
  logic [CNTW-1:0]         tx_cnt, tx_cnt_d;
  logic [IDXW-1:0]         tx_idx, tx_idx_d;
  tx_state_e               tx_state, tx_next;

  logic                    rx_s1, rx_s2, rx_valid, rx_valid_d, rx_break_d, rx_push;
  logic [PAYLOAD_BITS-1:0] rx_sh, rx_sh_d;
  logic [CNTW-1:0]         rx_cnt, rx_cnt_d;
  logic [IDXW-1:0]         rx_idx, rx_idx_d;
  rx_state_e               rx_state, rx_next;

  uart_fifo_buf #(.WIDTH(PAYLOAD_BITS), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .wr(tx_write), .wdata(tx_data), .rd(tx_pop),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo_buf #(.WIDTH(PAYLOAD_BITS), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .wr(rx_push), .wdata(rx_sh), .rd(rx_read),
    .rdata(rx_data), .full(rx_full), .empty(rx_empty)
  );

  // Launch holdoff: busy only rises two cycles after the pop, so skip one cycle.
  assign tx_busy = (tx_state != TX_IDLE);
  assign tx_pop  = !tx_busy && !tx_empty && !tx_launch;
  assign rx_push = rx_valid && !rx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_launch  <= 1'b0;
      tx_byte    <= '0;
      rx_overrun <= 1'b0;
    end else begin
      tx_launch  <= tx_pop;
      if (tx_pop) tx_byte <= tx_head;
      rx_overrun <= rx_valid && rx_full;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= tx_cnt_d;
      tx_idx   <= tx_idx_d;
      tx_sh    <= tx_sh_d;
      txd      <= txd_d;
    end
  end

  // TX frame sequencer: start, LSB-first data, stop; txd is the registered line.
  always_comb begin
    tx_next  = tx_state;
    tx_cnt_d = tx_cnt + CNTW'(1);
    tx_idx_d = tx_idx;
    tx_sh_d  = tx_sh;
    txd_d    = txd;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        if (tx_launch) begin
          tx_sh_d = tx_byte;
          txd_d   = 1'b0;
          tx_next = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == CNTW'(CPB - 1)) begin
          tx_cnt_d = '0;
          tx_idx_d = '0;
          txd_d    = tx_sh[0];
          tx_next  = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt == CNTW'(CPB - 1)) begin
          tx_cnt_d = '0;
          if (tx_idx == IDXW'(PAYLOAD_BITS - 1)) begin
            txd_d   = 1'b1;
            tx_next = TX_STOP;
          end else begin
            tx_idx_d = tx_idx + IDXW'(1);
            tx_sh_d  = {1'b0, tx_sh[PAYLOAD_BITS-1:1]};
            txd_d    = tx_sh[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt == CNTW'(CPB - 1)) begin
          tx_cnt_d = '0;
          tx_next  = TX_IDLE;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
      rx_valid <= 1'b0;
      rx_break <= 1'b0;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_state <= rx_next;
      rx_cnt   <= rx_cnt_d;
      rx_idx   <= rx_idx_d;
      rx_sh    <= rx_sh_d;
      rx_valid <= rx_valid_d;
      rx_break <= rx_break_d;
    end
  end

  // RX sampler: half-bit start qualification, then mid-bit samples every CPB cycles.
  always_comb begin
    rx_next    = rx_state;
    rx_cnt_d   = rx_cnt + CNTW'(1);
    rx_idx_d   = rx_idx;
    rx_sh_d    = rx_sh;
    rx_valid_d = 1'b0;
    rx_break_d = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2) rx_next = RX_START;
      end
      RX_START: begin
        if (rx_cnt == CNTW'(HALF - 1)) begin
          rx_cnt_d = '0;
          rx_idx_d = '0;
          rx_next  = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNTW'(CPB - 1)) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2, rx_sh[PAYLOAD_BITS-1:1]};
          if (rx_idx == IDXW'(PAYLOAD_BITS - 1)) rx_next = RX_STOP;
          else rx_idx_d = rx_idx + IDXW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == CNTW'(CPB - 1)) begin
          rx_cnt_d = '0;
          if (rx_s2) begin
            rx_valid_d = 1'b1;
            rx_next    = RX_IDLE;
          end else begin
            rx_break_d = (rx_sh == '0);
            rx_next    = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        rx_cnt_d = '0;
        if (rx_s2) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// Self-checking bench: frame-level TX decoder, bit-banged RX driver, queue models.

module tb_uart_fifo_transceiver;
  localparam int unsigned CLK_HZ   = 1000000;
  localparam int unsigned BIT_RATE = 100000;
  localparam int unsigned PB       = 8;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned CPB      = CLK_HZ / BIT_RATE;

  logic          clk = 1'b0, rst = 1'b1;
  logic          tx_write = 1'b0, rx_read = 1'b0, rxd_drv = 1'b1, loopback = 1'b0;
  logic [PB-1:0] tx_data = '0;
  logic          txd, tx_full, tx_empty, rx_empty, rx_full, rx_break, rx_overrun;
  logic [PB-1:0] rx_data;
  wire           rxd;

  int checks = 0, failures = 0;
  int cyc = 0, brk_cnt = 0, ovr_cnt = 0, tx_bad = 0;
  logic [7:0] tx_seen[$];
  int         tx_start_t[$];

  assign rxd = loopback ? txd : rxd_drv;

  uart_fifo_transceiver #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd), .tx_write(tx_write), .tx_data(tx_data),
    .tx_full(tx_full), .tx_empty(tx_empty), .rx_read(rx_read), .rx_data(rx_data),
    .rx_empty(rx_empty), .rx_full(rx_full), .rx_break(rx_break), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_break === 1'b1)   brk_cnt <= brk_cnt + 1;
    if (rx_overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n, inout bit ab);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  // Independent frame decoder on txd; frames interrupted by reset are dropped.
  initial begin : tx_mon
    logic [7:0] b;
    bit         ab;
    int         t0;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        ab = 1'b0;
        t0 = cyc;
        wait_n(int'(CPB / 2), ab);
        if (txd !== 1'b0) ab = 1'b1;
        for (int i = 0; i < 8; i++) begin
          wait_n(int'(CPB), ab);
          b[i] = txd;
        end
        wait_n(int'(CPB), ab);
        if (!ab) begin
          if (txd === 1'b1) begin
            tx_seen.push_back(b);
            tx_start_t.push_back(t0);
          end else tx_bad++;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tx_write = 1'b0; rx_read = 1'b0; rxd_drv = 1'b1; loopback = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tx_seen.delete();
    tx_start_t.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd_drv = stop;
    repeat (CPB) @(negedge clk);
    rxd_drv = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, " nonempty"}, 32'(rx_empty), 32'(0));
    check(tag, 32'(rx_data), 32'(exp));
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] exp_q[$];
    logic [7:0] bytes[10];
    logic [9:0] frame;
    logic [7:0] b;
    int k, base, lows, exp_ovr;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst txd", 32'(txd), 32'(1));
    check("rst tx_empty", 32'(tx_empty), 32'(1));
    check("rst rx_empty", 32'(rx_empty), 32'(1));
    check("rst tx_full", 32'(tx_full), 32'(0));
    check("rst rx_full", 32'(rx_full), 32'(0));
    check("rst rx_data", 32'(rx_data), 32'(0));
    check("rst pulses", 32'({rx_break, rx_overrun}), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Exact TX waveform for 0xA5
    tx_data = 8'hA5; tx_write = 1'b1;
    @(negedge clk);
    tx_write = 1'b0;
    @(negedge clk);
    check("t1 tx_empty back", 32'(tx_empty), 32'(1));
    k = 0;
    while (txd !== 1'b0 && k < 10) begin @(negedge clk); k++; end
    check("t1 start seen", 32'(txd), 32'(0));
    frame = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int c = 0; c < int'(CPB); c++) begin
        check($sformatf("t1 bit%0d", i), 32'(txd), 32'(frame[i]));
        @(negedge clk);
      end
    repeat (5) begin
      check("t1 idle high", 32'(txd), 32'(1));
      @(negedge clk);
    end

    // Loopback: fixed and random bytes
    do_reset();
    loopback = 1'b1;
    base = ovr_cnt;
    exp_q = '{8'h00, 8'h55, 8'hFF};
    repeat (5) exp_q.push_back(8'($urandom_range(0, 255)));
    foreach (exp_q[i]) begin
      tx_data = exp_q[i]; tx_write = 1'b1;
      @(negedge clk);
    end
    tx_write = 1'b0;
    k = 0;
    while (tx_seen.size() < exp_q.size() && k < 1200) begin @(negedge clk); k++; end
    check("t2 frames sent", 32'(tx_seen.size()), 32'(exp_q.size()));
    repeat (60) @(negedge clk);
    check("t2 rx_full", 32'(rx_full), 32'(exp_q.size() >= DEPTH));
    foreach (exp_q[i]) pop_check($sformatf("t2 pop%0d", i), exp_q[i]);
    check("t2 rx_empty end", 32'(rx_empty), 32'(1));
    check("t2 no overrun", 32'(ovr_cnt - base), 32'(0));

    // TX FIFO overflow: one byte in flight plus DEPTH queued
    do_reset();
    for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 10; i++) begin
      tx_data = bytes[i]; tx_write = 1'b1;
      @(negedge clk);
    end
    tx_write = 1'b0;
    check("t3 tx_full", 32'(tx_full), 32'(1));
    k = 0;
    while (tx_seen.size() < DEPTH + 1 && k < 1300) begin @(negedge clk); k++; end
    repeat (300) @(negedge clk);
    check("t3 frame count", 32'(tx_seen.size()), 32'(DEPTH + 1));
    for (int i = 0; i < int'(DEPTH) + 1 && i < tx_seen.size(); i++)
      check($sformatf("t3 frame%0d", i), 32'(tx_seen[i]), 32'(bytes[i]));
    if (tx_start_t.size() == DEPTH + 1) begin
      check("t3 gap upper", 32'(tx_start_t[DEPTH] - tx_start_t[0] <= int'(DEPTH * (10 * CPB + 2))), 32'(1));
      check("t3 gap lower", 32'(tx_start_t[DEPTH] - tx_start_t[0] >= int'(DEPTH * 10 * CPB)), 32'(1));
    end
    check("t3 tx_empty end", 32'(tx_empty), 32'(1));

    // RX FIFO overflow
    do_reset();
    base = ovr_cnt; exp_ovr = 0;
    exp_q.delete();
    for (int i = 0; i < int'(DEPTH) + 1; i++) begin
      b = 8'($urandom_range(0, 255));
      if (exp_q.size() < DEPTH) exp_q.push_back(b); else exp_ovr++;
      send_frame(b, 1'b1);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      if (i == int'(DEPTH) - 1) check("t4 rx_full at depth", 32'(rx_full), 32'(1));
    end
    repeat (10) @(negedge clk);
    check("t4 overrun pulses", 32'(ovr_cnt - base), 32'(exp_ovr));
    foreach (exp_q[i]) pop_check($sformatf("t4 pop%0d", i), exp_q[i]);
    check("t4 rx_empty end", 32'(rx_empty), 32'(1));

    // Break, glitch, framing error
    do_reset();
    base = brk_cnt;
    rxd_drv = 1'b0;
    repeat (15 * CPB) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (30) @(negedge clk);
    check("t5 break pulse", 32'(brk_cnt - base), 32'(1));
    check("t5 break no data", 32'(rx_empty), 32'(1));
    rxd_drv = 1'b0;
    repeat (3) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (50) @(negedge clk);
    check("t5 glitch no break", 32'(brk_cnt - base), 32'(1));
    check("t5 glitch no data", 32'(rx_empty), 32'(1));
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1);
    repeat (5) @(negedge clk);
    pop_check("t5 after glitch", b);
    send_frame(8'($urandom_range(0, 255)) | 8'h01, 1'b0);
    repeat (30) @(negedge clk);
    check("t5 framing dropped", 32'(rx_empty), 32'(1));
    check("t5 framing no break", 32'(brk_cnt - base), 32'(1));
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1);
    repeat (5) @(negedge clk);
    pop_check("t5 after framing", b);

    // Reset in the middle of 0x3C with two bytes queued
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tx_data = (i == 0) ? 8'h3C : 8'($urandom_range(0, 255));
      tx_write = 1'b1;
      @(negedge clk);
    end
    tx_write = 1'b0;
    k = 0;
    while (txd !== 1'b0 && k < 10) begin @(negedge clk); k++; end
    repeat (CPB + CPB / 2) @(negedge clk);
    check("t6 pre-reset low bit", 32'(txd), 32'(0));
    #2 rst = 1'b1;
    #1;
    check("t6 txd immediate", 32'(txd), 32'(1));
    check("t6 tx_empty", 32'(tx_empty), 32'(1));
    check("t6 tx_full", 32'(tx_full), 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tx_seen.delete();
    lows = 0;
    repeat (400) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check("t6 line stays idle", 32'(lows), 32'(0));
    check("t6 nothing sent", 32'(tx_seen.size()), 32'(0));
    check("t6 rx_empty", 32'(rx_empty), 32'(1));
    check("tx decoder bad stops", 32'(tx_bad), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_fifo_transceiver.md
Name: uart_fifo_transceiver

Overview:
- Buffered 8N1 UART transceiver: serial RX engine, serial TX engine, one TX FIFO and one RX FIFO, plus glue logic.
- Sits under the memory-mapped UART peripheral.
- The CPU side pushes bytes into the TX FIFO and pops received bytes from the RX FIFO.
- The serial side runs at a fixed, integer-derived bit period.

Parameters:
- CLK_HZ, 25000000: system clock frequency in Hz.
- BIT_RATE, 9600: baud rate. CYCLES_PER_BIT = CLK_HZ/BIT_RATE, integer division, must be ≥4.
- PAYLOAD_BITS, 8: data bits per frame, also the FIFO width.
- DEPTH, 8: entries per FIFO, power of two.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rxd  in  1  serial input, idle high, asynchronous to clk.
- txd  out  1  serial output, idle high.
- tx_write  in  1  push tx_data into the TX FIFO.
- tx_data  in  PAYLOAD_BITS  byte to transmit.
- tx_full  out  1  TX FIFO full.
- tx_empty  out  1  TX FIFO empty.
- rx_read  in  1  pop the RX FIFO head.
- rx_data  out  PAYLOAD_BITS  RX FIFO head (first-word fall-through).
- rx_empty  out  1  RX FIFO empty.
- rx_full  out  1  RX FIFO full.
- rx_break  out  1  one-cycle pulse: break frame received.
- rx_overrun  out  1  one-cycle pulse: valid byte dropped because the RX FIFO was full.

Behaviour:
- Reset:
  - txd=1; both FIFOs empty (tx_empty=1, rx_empty=1, fulls=0); rx_data=0.
  - Pulses 0; engines idle; RX synchronizer flops = 1.
- FIFOs (two identical instances):
  - Circular buffer with read/write pointers and an occupancy count 0..DEPTH; full = count==DEPTH, empty = count==0.
  - Write is accepted only when !full. A write while full is ignored; data is lost and the pointer is unchanged.
  - Read is accepted only when !empty. A read while empty is ignored.
  - Read and write in the same cycle with the FIFO neither empty nor full: both performed, count unchanged.
  - Same cycle while full: read only. Same cycle while empty: write only.
  - Head data is valid combinationally whenever !empty. After a pop it shows the next entry in the following cycle.
  - Pointers wrap modulo DEPTH.
- TX engine:
  - Idle with txd=1. On an en pulse while idle: latch the byte, busy=1 from the next cycle.
  - Frame: start bit 0, PAYLOAD_BITS data bits LSB first, one stop bit 1. Each bit lasts CYCLES_PER_BIT cycles.
  - busy drops after the stop bit completes. An en pulse while busy is ignored.
- TX glue, registered:
  - When the engine is not busy, TX FIFO not empty, and no launch in the previous cycle: pulse en for one cycle with the FIFO head, and pop the FIFO the same cycle.
  - The one-cycle holdoff prevents a double pop before busy rises.
  - Back-to-back bytes leave at most 2 idle-high clock cycles between the stop bit and the next start bit.
- RX engine:
  - rxd passes through a 2-flop synchronizer.
  - IDLE: a low sample moves to START.
  - START: wait CYCLES_PER_BIT/2 cycles. Sample still low → DATA; high → glitch, back to IDLE.
  - DATA: sample each bit at mid-bit, every CYCLES_PER_BIT cycles, shifting LSB first.
  - STOP: sample at mid-bit.
    - Stop=1: one-cycle valid with the byte.
    - Stop=0 and all data bits 0: rx_break pulse; byte not stored.
    - Stop=0 and data nonzero: framing error; byte discarded silently.
  - Return to IDLE only after rxd is seen high, so a break held low does not retrigger.
- RX glue:
  - On valid: if !rx_full, push the byte into the RX FIFO next cycle.
  - If rx_full, drop the byte and pulse rx_overrun.
  - rx_read pops per the FIFO rules.
- Reset mid-frame: the transmitting frame is aborted, txd=1 immediately, and both FIFOs are cleared.

Test Plan:
- CLK_HZ=1000000, BIT_RATE=100000 (10 cycles/bit): write 0xA5 → txd low 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then high. tx_empty returns to 1 within 2 cycles of the write.
- Loop txd to rxd, write 0x00,0x55,0xFF → rx_empty drops. Three pops return 0x00, 0x55, 0xFF in order, then rx_empty=1.
- Write 10 bytes back-to-back with the transmitter busy → tx_full asserts once 8 bytes are queued. The extra writes are dropped. Exactly 9 frames are sent (1 in flight + 8).
- Drive 9 valid frames into rxd with no reads → rx_full=1 after 8, one rx_overrun pulse on the 9th. Popping returns the first 8 bytes only.
- Hold rxd low for 15 bit periods → one rx_break pulse, rx_empty stays 1. A 3-cycle low glitch → no activity.
- Assert rst mid-transmission of 0x3C with 2 bytes queued → txd=1 immediately, tx_empty=1, nothing further sent.
